myfilter_decimator: RTL and testbench

Downstream stage of `myfilter`. It consumes the filter's output sample strobe (`ext_out` / `extvalid_out`) and averages each block of 2^DECIM_LOG2 consecutive samples into one result. Results are buffered in a small FIFO and delivered to the next consumer over a valid/ready handshake. Overflow is reported with a sticky flag and a saturating drop counter.

---
 rtl/myfilter_decimator.sv | 102 ++++++++++
 tb/tb_myfilter_decimator.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/myfilter_decimator.sv
// Block averager behind myfilter: sums 2^DECIM_LOG2 strobed samples, pushes the floor-mean
// into a small register FIFO drained over valid/ready, and tracks dropped results.
module myfilter_decimator #(
    parameter int unsigned DATABITS   = 16,
    parameter int unsigned DECIM_LOG2 = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATABITS-1:0]           filt_in,
    input  logic                          filtvalid_in,
    output logic [DATABITS-1:0]           avg_out,
    output logic                          avgvalid_out,
    input  logic                          avgready_in,
    output logic [$clog2(FIFO_DEPTH):0]   level_out,
    output logic                          overflow_out,
    output logic [7:0]                    dropcnt_out
);

    localparam int unsigned AccW = DATABITS + DECIM_LOG2;
    localparam int unsigned CntW = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam logic [CntW-1:0] CntLast = CntW'((1 << DECIM_LOG2) - 1);
    localparam logic [PtrW:0]   LvlFull = (PtrW + 1)'(FIFO_DEPTH);

    logic signed [AccW-1:0]   acc_q, acc_d, sum;
    logic [CntW-1:0]          cnt_q, cnt_d;
    logic [DATABITS-1:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]            level_q, level_d;
    logic                     overflow_q, overflow_d;
    logic [7:0]               dropcnt_q, dropcnt_d;
    logic [DATABITS-1:0]      result;
    logic                     push, pop, full, push_ok, drop;

    always_comb begin
        sum      = acc_q + AccW'($signed(filt_in));
        // Arithmetic shift floors toward -inf; the mean always fits in DATABITS.
        result   = DATABITS'(sum >>> DECIM_LOG2);
        push     = filtvalid_in && (cnt_q == CntLast);
        pop      = (level_q != '0) && avgready_in;
        full     = (level_q == LvlFull);
        push_ok  = push && (!full || pop);
        drop     = push && full && !pop;

        acc_d      = acc_q;
        cnt_d      = cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        dropcnt_d  = dropcnt_q;

        if (filtvalid_in) begin
            if (push) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CntW'(1);
            end
        end
        if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + PtrW'(1);
        if (push_ok && !pop)      level_d = level_q + (PtrW + 1)'(1);
        else if (pop && !push_ok) level_d = level_q - (PtrW + 1)'(1);
        if (drop) begin
            overflow_d = 1'b1;
            if (dropcnt_q != 8'hFF) dropcnt_d = dropcnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            dropcnt_q  <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            dropcnt_q  <= dropcnt_d;
            // When full with a simultaneous pop, wr_ptr equals rd_ptr and the slot is freed.
            if (push_ok) mem_q[wr_ptr_q] <= result;
        end
    end

    assign avg_out      = mem_q[rd_ptr_q];
    assign avgvalid_out = (level_q != '0);
    assign level_out    = level_q;
    assign overflow_out = overflow_q;
    assign dropcnt_out  = dropcnt_q;

endmodule

// File: tb/tb_myfilter_decimator.sv
// Directed bench for myfilter_decimator: queue-based reference model checked every cycle,
// plus literal expectations for each directed scenario.
module tb_myfilter_decimator;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] filt_in;
    logic        filtvalid_in;
    logic [15:0] avg_out;
    logic        avgvalid_out;
    logic        avgready_in;
    logic [2:0]  level_out;
    logic        overflow_out;
    logic [7:0]  dropcnt_out;

    int vectors     = 0;
    int miscompares = 0;
    bit cmp_en      = 1'b0;

    // Reference model state
    logic [15:0] mq[$];
    int          m_sum  = 0;
    int          m_cnt  = 0;
    bit          m_ovf  = 1'b0;
    int          m_drop = 0;

    myfilter_decimator #(
        .DATABITS   (16),
        .DECIM_LOG2 (2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .filt_in      (filt_in),
        .filtvalid_in (filtvalid_in),
        .avg_out      (avg_out),
        .avgvalid_out (avgvalid_out),
        .avgready_in  (avgready_in),
        .level_out    (level_out),
        .overflow_out (overflow_out),
        .dropcnt_out  (dropcnt_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit          popping, pushing;
        int          pre;
        int          r;
        logic [15:0] res;
        if (rst) begin
            mq.delete();
            m_sum  = 0;
            m_cnt  = 0;
            m_ovf  = 1'b0;
            m_drop = 0;
            return;
        end
        pre     = mq.size();
        popping = (pre > 0) && avgready_in;
        pushing = 1'b0;
        res     = '0;
        if (filtvalid_in) begin
            m_sum += int'($signed(filt_in));
            m_cnt++;
            if (m_cnt == 4) begin
                r       = m_sum >>> 2;
                res     = r[15:0];
                pushing = 1'b1;
                m_sum   = 0;
                m_cnt   = 0;
            end
        end
        if (popping) void'(mq.pop_front());
        if (pushing) begin
            if (pre < 4 || popping) mq.push_back(res);
            else begin
                m_ovf = 1'b1;
                if (m_drop < 255) m_drop++;
            end
        end
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (cmp_en) begin
            check("valid", 32'(avgvalid_out), 32'(mq.size() > 0));
            if (mq.size() > 0) check("data", 32'(avg_out), 32'(mq[0]));
            check("level", 32'(level_out), 32'(mq.size()));
            check("ovf", 32'(overflow_out), 32'(m_ovf));
            check("drop", 32'(dropcnt_out), 32'(m_drop));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [15:0] v);
        filtvalid_in = 1'b1;
        filt_in      = v;
        tick();
        filtvalid_in = 1'b0;
    endtask

    task automatic block4(input logic [15:0] a, b, c, d);
        strobe(a);
        strobe(b);
        strobe(c);
        strobe(d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        filt_in      = '0;
        filtvalid_in = 1'b0;
        avgready_in  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_avg", 32'(avg_out), 32'h0);
        check("rst_valid", 32'(avgvalid_out), 32'h0);
        check("rst_level", 32'(level_out), 32'h0);
        check("rst_ovf", 32'(overflow_out), 32'h0);
        check("rst_drop", 32'(dropcnt_out), 32'h0);
        cmp_en = 1'b1;

        // 1: basic average with 1-cycle latency
        avgready_in = 1'b1;
        block4(16'd1, 16'd2, 16'd3, 16'd4);
        check("s1_valid", 32'(avgvalid_out), 32'h1);
        check("s1_avg", 32'(avg_out), 32'h2);
        check("s1_level1", 32'(level_out), 32'h1);
        tick();
        check("s1_valid_fall", 32'(avgvalid_out), 32'h0);
        check("s1_level0", 32'(level_out), 32'h0);

        // 2: floor rounding of negative and positive sums
        block4(16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFD);
        check("s2_neg", 32'(avg_out), 32'hFFFD);
        tick();
        block4(16'd1, 16'd1, 16'd1, 16'd2);
        check("s2_pos", 32'(avg_out), 32'h1);
        tick();

        // 3: extremes
        block4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        check("s3_max", 32'(avg_out), 32'h7FFF);
        tick();
        block4(16'h8000, 16'h8000, 16'h8000, 16'h8000);
        check("s3_min", 32'(avg_out), 32'h8000);
        check("s3_ovf", 32'(overflow_out), 32'h0);
        tick();

        // 4: stall consumer over 5 blocks with gaps; block k averages to 16k+1
        avgready_in = 1'b0;
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 4; j++) begin
                strobe(16'(k * 16 + j));
                repeat ($urandom_range(0, 2)) tick();
            end
        end
        check("s4_level", 32'(level_out), 32'h4);
        check("s4_ovf", 32'(overflow_out), 32'h1);
        check("s4_drop", 32'(dropcnt_out), 32'h1);
        avgready_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("s4_order", 32'(avg_out), 32'(k * 16 + 1));
            tick();
        end
        check("s4_empty", 32'(avgvalid_out), 32'h0);
        check("s4_ovf_sticky", 32'(overflow_out), 32'h1);

        // 5: full FIFO, pop coincides with the completing strobe
        avgready_in = 1'b0;
        for (int k = 0; k < 4; k++) block4(16'(4 * k), 16'(4 * k), 16'(4 * k), 16'(4 * k));
        check("s5_full", 32'(level_out), 32'h4);
        strobe(16'd40);
        strobe(16'd40);
        strobe(16'd40);
        avgready_in = 1'b1;
        strobe(16'd40);
        avgready_in = 1'b0;
        check("s5_level", 32'(level_out), 32'h4);
        check("s5_drop", 32'(dropcnt_out), 32'h1);
        check("s5_head", 32'(avg_out), 32'h4);
        avgready_in = 1'b1;
        repeat (5) tick();

        // 6: reset mid-block with a coinciding strobe
        avgready_in = 1'b0;
        strobe(16'd100);
        strobe(16'd100);
        rst          = 1'b1;
        filtvalid_in = 1'b1;
        filt_in      = 16'd100;
        tick();
        rst          = 1'b0;
        filtvalid_in = 1'b0;
        check("s6_ovf", 32'(overflow_out), 32'h0);
        check("s6_drop", 32'(dropcnt_out), 32'h0);
        check("s6_level", 32'(level_out), 32'h0);
        check("s6_valid", 32'(avgvalid_out), 32'h0);
        avgready_in = 1'b1;
        block4(16'd8, 16'd8, 16'd8, 16'd8);
        check("s6_avg", 32'(avg_out), 32'h8);
        check("s6_level1", 32'(level_out), 32'h1);
        tick();
        check("s6_single", 32'(avgvalid_out), 32'h0);
        tick();

        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
